// File: rtl/bram_fifo_ctrl.sv
// Stream FIFO controller driving an external simple-dual-port BRAM (A = write, B = read).
// A 2-entry output stage hides the BRAM's registered read latency for one word per cycle.
module bram_fifo_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [ADDR_WIDTH+1:0] o_level,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_bram_ena,
    output logic                  o_bram_wea,
    output logic [ADDR_WIDTH-1:0] o_bram_addra,
    output logic [DATA_WIDTH-1:0] o_bram_dia,
    output logic                  o_bram_enb,
    output logic [ADDR_WIDTH-1:0] o_bram_addrb,
    input  logic [DATA_WIDTH-1:0] i_bram_dob
);

    localparam int                    CNT_W     = ADDR_WIDTH + 1;
    localparam int                    LVL_W     = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_mem_cnt;
    logic                  r_rd_pend;
    logic [1:0]            r_ob_cnt;
    logic [DATA_WIDTH-1:0] r_ob0;
    logic [DATA_WIDTH-1:0] r_ob1;

    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_slots_used;
    logic                  w_cap_hi;
    logic [DATA_WIDTH-1:0] w_ob0_nxt;
    logic [DATA_WIDTH-1:0] w_ob1_nxt;

    function automatic logic [ADDR_WIDTH-1:0] f_next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_s_ready = (r_mem_cnt != FULL_CNT) && !i_flush && !i_rst;
    assign w_accept  = i_s_valid && w_s_ready;
    assign w_pop     = (r_ob_cnt != 2'd0) && i_m_ready;

    // Output-stage slots that stay committed after this cycle's pop; a read may issue only
    // if its data will have a free slot when it returns.
    assign w_slots_used = 3'(r_ob_cnt) + 3'(r_rd_pend) - 3'(w_pop);
    assign w_issue      = (r_mem_cnt != '0) && (w_slots_used < 3'd2);

    // Returning data lands behind whatever word survives this cycle's pop.
    assign w_cap_hi = (r_ob_cnt == 2'd1) && !w_pop;

    always_comb begin
        w_ob0_nxt = r_ob0;
        w_ob1_nxt = r_ob1;
        if (w_pop) begin
            w_ob0_nxt = r_ob1;
        end
        if (r_rd_pend) begin
            if (w_cap_hi) begin
                w_ob1_nxt = i_bram_dob;
            end else begin
                w_ob0_nxt = i_bram_dob;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_ob_cnt  <= 2'd0;
            r_ob0     <= '0;
            r_ob1     <= '0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_ob_cnt  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_issue) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            unique case ({w_accept, w_issue})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            r_rd_pend <= w_issue;
            r_ob_cnt  <= r_ob_cnt + 2'(r_rd_pend) - 2'(w_pop);
            r_ob0     <= w_ob0_nxt;
            r_ob1     <= w_ob1_nxt;
        end
    end

    assign o_s_ready    = w_s_ready;
    assign o_bram_ena   = w_accept;
    assign o_bram_wea   = w_accept;
    assign o_bram_addra = w_accept ? r_wr_ptr : '0;
    assign o_bram_dia   = w_accept ? i_s_data : '0;
    assign o_bram_enb   = w_issue;
    assign o_bram_addrb = w_issue ? r_rd_ptr : '0;

    assign o_m_valid = (r_ob_cnt != 2'd0);
    assign o_m_data  = r_ob0;
    assign o_level   = LVL_W'(r_mem_cnt) + LVL_W'(r_rd_pend) + LVL_W'(r_ob_cnt);
    assign o_full    = (r_mem_cnt == FULL_CNT);
    assign o_empty   = (o_level == '0);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl (DEPTH=16) with a behavioural registered-read BRAM model:
// a per-cycle vector table, then reset, fill, streaming, random and flush sequences.
module tb_bram_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 24;
    localparam int LW    = AW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          bram_ena;
    logic          bram_wea;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_dia;
    logic          bram_enb;
    logic [AW-1:0] bram_addrb;
    logic [DW-1:0] bram_dob;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_level(level), .o_full(full), .o_empty(empty),
        .o_bram_ena(bram_ena), .o_bram_wea(bram_wea), .o_bram_addra(bram_addra),
        .o_bram_dia(bram_dia), .o_bram_enb(bram_enb), .o_bram_addrb(bram_addrb),
        .i_bram_dob(bram_dob)
    );

    // Simple-dual-port BRAM with registered read address
    logic [DW-1:0] bmem [DEPTH];
    always @(posedge clk) if (bram_ena && bram_wea) bmem[bram_addra] <= bram_dia;
    always @(posedge clk or posedge rst)
        if (rst) bram_dob <= '0;
        else if (bram_enb) bram_dob <= bmem[bram_addrb];

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name);
        logic [DW-1:0] e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got word %0h expected no output", name, m_data);
        end else begin
            e = q.pop_front();
            chk(name, 32'(m_data), 32'(e));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        #1;
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          fl;
        logic          e_ena;
        logic [AW-1:0] e_addra;
        logic          e_enb;
        logic [AW-1:0] e_addrb;
        logic          e_srdy;
        logic          e_mv;
        logic          chk_d;
        logic [DW-1:0] e_md;
        logic [LW-1:0] e_lvl;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic [DW-1:0] sd, input logic mr,
                                input logic fl, input logic ena, input logic [AW-1:0] aa,
                                input logic enb, input logic [AW-1:0] ab, input logic srdy,
                                input logic mv, input logic cd, input logic [DW-1:0] md,
                                input logic [LW-1:0] lvl);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl;
        v.e_ena = ena; v.e_addra = aa; v.e_enb = enb; v.e_addrb = ab;
        v.e_srdy = srdy; v.e_mv = mv; v.chk_d = cd; v.e_md = md; v.e_lvl = lvl;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd, acc, popn, first_acc, first_out, last_out, zero_w, stalls, n_acc;
        logic          found;
        logic [DW-1:0] got;

        //          sv  sd          mr fl   ena aa  enb ab  srdy mv cd md          lvl
        tbl[0]  = mk(1, 24'hA00001, 0, 0,   1,  0,  0,  0,  1,   0, 0, 24'h0,      0);
        tbl[1]  = mk(1, 24'hA00002, 0, 0,   1,  1,  1,  0,  1,   0, 0, 24'h0,      1);
        tbl[2]  = mk(0, 24'h0,      0, 0,   0,  0,  1,  1,  1,   0, 0, 24'h0,      2);
        tbl[3]  = mk(0, 24'h0,      0, 0,   0,  0,  0,  0,  1,   1, 1, 24'hA00001, 2);
        tbl[4]  = mk(1, 24'hA00003, 1, 0,   1,  2,  0,  0,  1,   1, 1, 24'hA00001, 2);
        tbl[5]  = mk(0, 24'h0,      1, 0,   0,  0,  1,  2,  1,   1, 1, 24'hA00002, 2);
        tbl[6]  = mk(0, 24'h0,      1, 0,   0,  0,  0,  0,  1,   0, 0, 24'h0,      1);
        tbl[7]  = mk(0, 24'h0,      1, 0,   0,  0,  0,  0,  1,   1, 1, 24'hA00003, 1);
        tbl[8]  = mk(0, 24'h0,      0, 0,   0,  0,  0,  0,  1,   0, 0, 24'h0,      0);
        tbl[9]  = mk(1, 24'hB00001, 0, 0,   1,  3,  0,  0,  1,   0, 0, 24'h0,      0);
        tbl[10] = mk(1, 24'hB00002, 0, 0,   1,  4,  1,  3,  1,   0, 0, 24'h0,      1);
        tbl[11] = mk(1, 24'hB00003, 0, 0,   1,  5,  1,  4,  1,   0, 0, 24'h0,      2);
        tbl[12] = mk(1, 24'hB00004, 0, 1,   0,  0,  0,  0,  0,   1, 1, 24'hB00001, 3);
        tbl[13] = mk(1, 24'hC00001, 1, 0,   1,  0,  0,  0,  1,   0, 0, 24'h0,      0);
        tbl[14] = mk(0, 24'h0,      1, 0,   0,  0,  1,  0,  1,   0, 0, 24'h0,      1);
        tbl[15] = mk(0, 24'h0,      1, 0,   0,  0,  0,  0,  1,   0, 0, 24'h0,      1);
        tbl[16] = mk(0, 24'h0,      1, 0,   0,  0,  0,  0,  1,   1, 1, 24'hC00001, 1);
        tbl[17] = mk(0, 24'h0,      0, 0,   0,  0,  0,  0,  1,   0, 0, 24'h0,      0);

        // Reset state, with a pending input that must not be written
        rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 24'h5A5A5A; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst m_valid", 32'(m_valid), 0);
        chk("rst m_data", 32'(m_data), 0);
        chk("rst level", 32'(level), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst s_ready", 32'(s_ready), 0);
        chk("rst bram_ena", 32'(bram_ena), 0);
        chk("rst bram_wea", 32'(bram_wea), 0);
        chk("rst bram_dia", 32'(bram_dia), 0);
        chk("rst bram_enb", 32'(bram_enb), 0);
        chk("rst bram_addrb", 32'(bram_addrb), 0);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        #1;
        chk("release s_ready", 32'(s_ready), 1);

        // Per-cycle vector table
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].fl);
            chk($sformatf("vec%0d bram_ena", i), 32'(bram_ena), 32'(tbl[i].e_ena));
            if (tbl[i].e_ena) chk($sformatf("vec%0d bram_addra", i), 32'(bram_addra), 32'(tbl[i].e_addra));
            if (tbl[i].e_ena) chk($sformatf("vec%0d bram_dia", i), 32'(bram_dia), 32'(tbl[i].sd));
            chk($sformatf("vec%0d bram_enb", i), 32'(bram_enb), 32'(tbl[i].e_enb));
            if (tbl[i].e_enb) chk($sformatf("vec%0d bram_addrb", i), 32'(bram_addrb), 32'(tbl[i].e_addrb));
            chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_srdy));
            chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            if (tbl[i].chk_d) chk($sformatf("vec%0d m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].e_lvl));
        end

        // Asynchronous reset with level 5
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(24'h500 + i), 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        chk("pre-reset level", 32'(level), 5);
        chk("pre-reset m_valid", 32'(m_valid), 1);
        @(negedge clk);
        s_valid = 1'b1; s_data = 24'h123456; m_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async rst level", 32'(level), 0);
        chk("async rst m_valid", 32'(m_valid), 0);
        chk("async rst bram_ena", 32'(bram_ena), 0);
        chk("async rst bram_enb", 32'(bram_enb), 0);
        chk("async rst s_ready", 32'(s_ready), 0);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("post-rst s_ready", 32'(s_ready), 1);
        chk("post-rst empty", 32'(empty), 1);

        // Fill to full with m_ready low, then drain
        n_acc = 0;
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, DW'(24'h100 + n_acc), 1'b0, 1'b0);
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                n_acc++;
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("fill accepted", 32'(n_acc), 18);
        chk("fill level", 32'(level), 18);
        chk("fill full", 32'(full), 1);
        chk("fill s_ready", 32'(s_ready), 0);
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            if (m_valid) check_pop("drain data");
        end
        chk("drain remaining", 32'(q.size()), 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("drain empty", 32'(empty), 1);
        chk("drain level", 32'(level), 0);

        // Streaming 1000 words, m_ready held high
        drive(1'b0, '0, 1'b1, 1'b1);
        q.delete();
        sent = 0; rcvd = 0; first_acc = -1; first_out = -1; last_out = -1; zero_w = 0; stalls = 0;
        for (int c = 0; c < 1200 && rcvd < 1000; c++) begin
            drive(sent < 1000, DW'(sent), 1'b1, 1'b0);
            if (s_valid && s_ready) begin
                if (first_acc < 0) first_acc = c;
                q.push_back(s_data);
                sent++;
            end
            if (s_valid && !s_ready) stalls++;
            if (bram_ena && bram_addra == '0) zero_w++;
            if (m_valid) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                rcvd++;
                check_pop("stream data");
            end
        end
        chk("stream words out", 32'(rcvd), 1000);
        chk("stream fill latency", 32'(first_out - first_acc), 3);
        chk("stream no bubbles", 32'(last_out - first_out), 999);
        chk("stream input stalls", 32'(stalls), 0);
        chk("stream pointer wraps", 32'(zero_w - 1), 62);

        // Random handshakes, 10k words
        drive(1'b0, '0, 1'b0, 1'b1);
        q.delete();
        acc = 0; popn = 0; sent = 0;
        for (int c = 0; c < 60000 && popn < 10000; c++) begin
            drive((sent < 10000) && ($urandom_range(0, 1) == 1), DW'($urandom),
                  $urandom_range(0, 1) == 1, 1'b0);
            chk("rand level", 32'(level), 32'(acc - popn));
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                acc++;
                sent++;
            end
            if (m_valid && m_ready) begin
                check_pop("rand data");
                popn++;
            end
        end
        chk("rand words out", 32'(popn), 10000);

        // Flush at level 7 with a read in flight
        for (int i = 0; i < 7; i++) drive(1'b1, DW'(24'h700 + i), 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        chk("pre-flush level", 32'(level), 7);
        drive(1'b1, 24'h7000FF, 1'b1, 1'b0);
        chk("pre-flush issue", 32'(bram_enb), 1);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("flush-cycle level", 32'(level), 7);
        chk("flush-cycle s_ready", 32'(s_ready), 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("post-flush level", 32'(level), 0);
        chk("post-flush m_valid", 32'(m_valid), 0);
        drive(1'b1, 24'hFEED01, 1'b1, 1'b0);
        found = 1'b0;
        got   = '0;
        for (int c = 0; c < 10 && !found; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            if (m_valid) begin
                found = 1'b1;
                got   = m_data;
            end
        end
        chk("post-flush word seen", 32'(found), 1);
        chk("post-flush first word", 32'(got), 32'h00FEED01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
